// File: rtl/shift_rows_stream.sv
// AES/Rijndael ShiftRows / InvShiftRows applied per block on input acceptance,
// buffered in a 2-entry FIFO with valid/ready handshakes and a pop counter.
module shift_rows_stream #(
  parameter int NB    = 4,
  parameter int CNT_W = 16,
  localparam int W    = 32 * NB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_text,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_text,
  output logic             out_mode,
  output logic [CNT_W-1:0] blk_count
);

  if (!((NB == 4) || (NB == 6) || (NB == 8))) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  // Rijndael row offsets; the 256-bit block uses a wider spread on rows 2 and 3.
  function automatic int f_offset(input int row);
    case (row)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      3:       return (NB == 8) ? 4 : 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] f_shift_rows(input logic [W-1:0] text, input logic mode);
    logic [W-1:0] res;
    int           src;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        if (mode == 1'b0) begin
          src = (c + f_offset(r)) % NB;
        end else begin
          src = (c - f_offset(r) + NB) % NB;
        end
        res[W-1-8*(4*c+r) -: 8] = text[W-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  logic [W-1:0]     r_mem_text [2];
  logic [1:0]       r_mem_mode;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_blk_count;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;
  logic [W-1:0]     w_xform;

  assign w_xform = f_shift_rows(in_text, in_mode);
  assign w_push  = in_valid && r_in_ready;
  assign w_pop   = (r_count != 2'd0) && out_ready;

  // Occupancy next-state; flush wins over any same-cycle push or pop.
  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = 2'd0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 2'd1;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // FIFO storage, pointers, occupancy, registered in_ready and pop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_text[0] <= '0;
      r_mem_text[1] <= '0;
      r_mem_mode    <= 2'b00;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_in_ready    <= 1'b0;
      r_blk_count   <= '0;
    end else begin
      if (flush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem_text[r_wr_ptr] <= w_xform;
          r_mem_mode[r_wr_ptr] <= in_mode;
          r_wr_ptr             <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr    <= ~r_rd_ptr;
          r_blk_count <= r_blk_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < 2'd2);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_text  = r_mem_text[r_rd_ptr];
  assign out_mode  = r_mem_mode[r_rd_ptr];
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Randomized self-checking bench: a queue-based reference of the FIFO plus a
// row-rotation model of ShiftRows, for NB=4 (main), NB=6 (CNT_W=4) and NB=8.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic f4 = 1'b0, iv4 = 1'b0, im4 = 1'b0, or4 = 1'b0;
  logic [127:0] it4 = '0, ot4;
  logic ir4, ov4, om4;
  logic [15:0] bc4;

  logic f6 = 1'b0, iv6 = 1'b0, im6 = 1'b0, or6 = 1'b0;
  logic [191:0] it6 = '0, ot6;
  logic ir6, ov6, om6;
  logic [3:0] bc6;

  logic f8 = 1'b0, iv8 = 1'b0, im8 = 1'b0, or8 = 1'b0;
  logic [255:0] it8 = '0, ot8;
  logic ir8, ov8, om8;
  logic [15:0] bc8;

  shift_rows_stream #(.NB(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(f4), .in_valid(iv4), .in_ready(ir4),
    .in_text(it4), .in_mode(im4), .out_valid(ov4), .out_ready(or4),
    .out_text(ot4), .out_mode(om4), .blk_count(bc4));

  shift_rows_stream #(.NB(6), .CNT_W(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .flush(f6), .in_valid(iv6), .in_ready(ir6),
    .in_text(it6), .in_mode(im6), .out_valid(ov6), .out_ready(or6),
    .out_text(ot6), .out_mode(om6), .blk_count(bc6));

  shift_rows_stream #(.NB(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(f8), .in_valid(iv8), .in_ready(ir8),
    .in_text(it8), .in_mode(im8), .out_valid(ov8), .out_ready(or8),
    .out_text(ot8), .out_mode(om8), .blk_count(bc8));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [127:0] text; logic mode; } entry_t;
  entry_t q[$];
  int     exp_blk = 0;
  bit     rdy_en  = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each row is a byte queue rotated left (encrypt) or right (decrypt).
  function automatic logic [255:0] ref_sr(input logic [255:0] t, input int nb, input bit m);
    byte unsigned row[$];
    logic [255:0] o;
    int offs[4];
    o = '0;
    offs = (nb == 8) ? '{0, 1, 3, 4} : '{0, 1, 2, 3};
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < nb; c++) row.push_back(t[32*nb-1-8*(4*c+r) -: 8]);
      repeat (offs[r]) begin
        if (!m) row.push_back(row.pop_front());
        else    row.push_front(row.pop_back());
      end
      for (int c = 0; c < nb; c++) o[32*nb-1-8*(4*c+r) -: 8] = row[c];
    end
    return o;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One NB=4 cycle: compare against the model at the negedge, then advance it.
  task automatic step4();
    logic [255:0] tmp;
    bit acc, pop;
    check("in_ready", ir4, rdy_en && (q.size() < 2));
    check("out_valid", ov4, q.size() > 0);
    if (q.size() > 0) begin
      check("out_text", ot4, q[0].text);
      check("out_mode", om4, q[0].mode);
    end
    check("blk_count", bc4, exp_blk[15:0]);
    acc = iv4 && rdy_en && (q.size() < 2);
    pop = (q.size() > 0) && or4;
    if (f4) begin
      q.delete();
    end else begin
      if (pop) begin
        void'(q.pop_front());
        exp_blk++;
      end
      if (acc) begin
        tmp = ref_sr({128'b0, it4}, 4, im4);
        q.push_back('{text: tmp[127:0], mode: im4});
      end
    end
    @(posedge clk);
    rdy_en = rst_n;
    @(negedge clk);
  endtask

  task automatic xfer6(input logic [191:0] t, input logic m, output logic [191:0] r);
    check("nb6_ready", ir6, 1);
    iv6 = 1'b1; it6 = t; im6 = m; or6 = 1'b0;
    @(posedge clk); @(negedge clk);
    iv6 = 1'b0;
    for (int i = 0; i < 8 && !ov6; i++) @(negedge clk);
    check("nb6_valid", ov6, 1);
    check("nb6_mode", om6, m);
    r = ot6;
    or6 = 1'b1;
    @(posedge clk); @(negedge clk);
    or6 = 1'b0;
  endtask

  task automatic xfer8(input logic [255:0] t, input logic m, output logic [255:0] r);
    check("nb8_ready", ir8, 1);
    iv8 = 1'b1; it8 = t; im8 = m; or8 = 1'b0;
    @(posedge clk); @(negedge clk);
    iv8 = 1'b0;
    for (int i = 0; i < 8 && !ov8; i++) @(negedge clk);
    check("nb8_valid", ov8, 1);
    check("nb8_mode", om8, m);
    r = ot8;
    or8 = 1'b1;
    @(posedge clk); @(negedge clk);
    or8 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] x, y, z, e;
    logic [191:0] y6, z6;
    logic [7:0] b_out, b_in;
    int blk0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", ir4, 0);
    check("rst_out_valid", ov4, 0);
    check("rst_blk", bc4, 0);
    check("rst_out_text", ot4, 0);
    check("rst_out_mode", om4, 0);
    rst_n = 1'b1;
    rdy_en = 1'b0;
    step4();
    step4();

    // Known-answer vectors, one cycle latency.
    iv4 = 1'b1; im4 = 1'b0; it4 = 128'hd42711aee0bf98f1b8b45de51e415230;
    step4();
    iv4 = 1'b0;
    check("kat_enc_valid", ov4, 1);
    check("kat_enc", ot4, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    check("kat_enc_mode", om4, 0);
    or4 = 1'b1; step4(); or4 = 1'b0;
    iv4 = 1'b1; im4 = 1'b1; it4 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    step4();
    iv4 = 1'b0;
    check("kat_dec", ot4, 128'hd42711aee0bf98f1b8b45de51e415230);
    check("kat_dec_mode", om4, 1);
    or4 = 1'b1; step4(); or4 = 1'b0;

    // Backpressure: three offers, two accepted, then release.
    iv4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = rnd256(); it4 = x[127:0]; im4 = x[200];
      step4();
    end
    check("bp_in_ready_low", ir4, 0);
    step4();
    iv4 = 1'b0; or4 = 1'b1;
    repeat (3) step4();
    or4 = 1'b0;

    // Streaming with alternating modes.
    blk0 = exp_blk;
    iv4 = 1'b1; or4 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      x = rnd256(); it4 = x[127:0]; im4 = i[0];
      step4();
    end
    check("stream_blk", bc4, blk0 + 99);
    iv4 = 1'b0;
    step4();
    or4 = 1'b0;

    // Full, then flush with a simultaneous pop and push offer.
    iv4 = 1'b1;
    repeat (2) begin
      x = rnd256(); it4 = x[127:0]; im4 = x[9];
      step4();
    end
    blk0 = exp_blk;
    f4 = 1'b1; or4 = 1'b1;
    step4();
    f4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
    check("flush_empty", ov4, 0);
    check("flush_blk", bc4, blk0);
    step4();

    // Random mixed traffic.
    for (int i = 0; i < 60; i++) begin
      x = rnd256(); it4 = x[127:0]; im4 = x[130];
      iv4 = x[131]; or4 = x[132];
      step4();
    end
    iv4 = 1'b0; or4 = 1'b1;
    repeat (3) step4();
    or4 = 1'b0;

    // Asynchronous reset with two entries held.
    iv4 = 1'b1;
    repeat (2) begin
      x = rnd256(); it4 = x[127:0]; im4 = x[3];
      step4();
    end
    iv4 = 1'b0;
    check("pre_rst_valid", ov4, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", ov4, 0);
    check("async_rst_ready", ir4, 0);
    q.delete(); exp_blk = 0; rdy_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step4();
    step4();
    check("post_rst_blk", bc4, 0);

    // NB=6 round trip and 4-bit counter wrap after 17 pops.
    x = rnd256();
    xfer6(x[191:0], 1'b0, y6);
    e = ref_sr({64'b0, x[191:0]}, 6, 1'b0);
    check("nb6_enc", y6, e);
    xfer6(y6, 1'b1, z6);
    check("nb6_roundtrip", z6, x[191:0]);
    for (int i = 0; i < 15; i++) begin
      x = rnd256();
      xfer6(x[191:0], x[255], y6);
      e = ref_sr({64'b0, x[191:0]}, 6, x[255]);
      check("nb6_rand", y6, e);
    end
    check("nb6_blk_wrap", bc6, 1);

    // NB=8 round trip and row offsets 0,1,3,4.
    x = rnd256();
    xfer8(x, 1'b0, y);
    e = ref_sr(x, 8, 1'b0);
    check("nb8_enc", y, e);
    b_out = y[255-8*3 -: 8]; b_in = x[255-8*19 -: 8];
    check("nb8_row3_c0", b_out, b_in);
    b_out = y[255-8*2 -: 8]; b_in = x[255-8*14 -: 8];
    check("nb8_row2_c0", b_out, b_in);
    xfer8(y, 1'b1, z);
    check("nb8_roundtrip", z, x);
    check("nb8_blk", bc8, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
